// File: rtl/mprj_stim_pkg.sv
// Shared types and constants for the mprj_io stimulus sequencer.
// Optional echo checker is enabled with MPRJ_STIM_ECHO_EN.
package mprj_stim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } stim_state_e;

  localparam logic [4:0] ADDR_CTRL = 5'd31;
  localparam logic [4:0] ADDR_ECHO = 5'd30;
  localparam logic [4:0] ADDR_STAT = 5'd29;

  // Entry word layout: {hold, status, checkbits}
  localparam int unsigned CHK_LSB  = 0;
  localparam int unsigned CHK_W    = 16;
  localparam int unsigned STAT_LSB = 16;
  localparam int unsigned STAT_W   = 4;
  localparam int unsigned HOLD_LSB = 20;
  localparam int unsigned IO_W     = CHK_W + STAT_W;

endpackage

// File: rtl/mprj_stim_pattern_ram.sv
// Pattern table: DEPTH x 32 register file with one write port and two read ports
// (sequencer and configuration readback). Contents are not reset.
module mprj_stim_pattern_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] seq_addr_i,
  output logic [31:0]      seq_rdata_o,
  input  logic [IDX_W-1:0] cfg_addr_i,
  output logic [31:0]      cfg_rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign seq_rdata_o = mem_q[seq_addr_i];
  assign cfg_rdata_o = mem_q[cfg_addr_i];

endmodule

// File: rtl/mprj_io_stim_sequencer.sv
// Plays a table of timed 20-bit patterns onto mprj_io[35:16] under register control.
// Define MPRJ_STIM_ECHO_EN to build the pad readback mismatch counter.
module mprj_io_stim_sequencer
  import mprj_stim_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned HOLD_W = 12,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             cfg_we,
  input  logic [4:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] step_idx,
  output logic [19:0]      io_out,
  output logic [19:0]      io_oeb,
  input  logic [19:0]      io_in
);

  stim_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, load_idx, last_q, last_wr;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IO_W-1:0]   out_q, out_d, oeb_q, oeb_d;
  logic              loop_q;
  logic              load, fin, start_ok, expiry, tbl_hit;
  logic [31:0]       seq_entry, tbl_rdata, echo_rd;

  assign tbl_hit  = 32'(cfg_addr) < DEPTH;
  assign start_ok = start & ~abort & (state_q == StIdle);
  assign expiry   = (state_q == StRun) && (hold_q == '0);

  mprj_stim_pattern_ram #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk_i      (clock),
    .we_i       (cfg_we & tbl_hit),
    .waddr_i    (cfg_addr[IDX_W-1:0]),
    .wdata_i    (cfg_wdata),
    .seq_addr_i (load_idx),
    .seq_rdata_o(seq_entry),
    .cfg_addr_i (cfg_addr[IDX_W-1:0]),
    .cfg_rdata_o(tbl_rdata)
  );

  // Out-of-range last index is clamped on write so the sequencer never walks off the table
  assign last_wr = (32'(cfg_wdata[IDX_W-1:0]) >= DEPTH) ? IDX_W'(DEPTH - 1)
                                                         : cfg_wdata[IDX_W-1:0];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      last_q <= '0;
      loop_q <= 1'b0;
    end else if (cfg_we && (cfg_addr == ADDR_CTRL)) begin
      last_q <= last_wr;
      loop_q <= cfg_wdata[IDX_W];
    end
  end

  // Which entry gets loaded next; CTRL is sampled only here, at expiry
  always_comb begin
    load     = 1'b0;
    load_idx = idx_q;
    fin      = 1'b0;
    if (start_ok) begin
      load     = 1'b1;
      load_idx = '0;
    end else if (!abort && expiry) begin
      if (idx_q < last_q) begin
        load     = 1'b1;
        load_idx = idx_q + 1'b1;
      end else if (loop_q) begin
        load     = 1'b1;
        load_idx = '0;
      end else begin
        fin = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    out_d   = out_q;
    oeb_d   = oeb_q;
    if (abort) begin
      state_d = StIdle;
      idx_d   = '0;
      hold_d  = '0;
      out_d   = '0;
      oeb_d   = '1;
    end else begin
      unique case (state_q)
        StIdle: if (start) state_d = StRun;
        StRun: begin
          if (fin) begin
            state_d = StDone;
          end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
      if (load) begin
        idx_d  = load_idx;
        hold_d = seq_entry[HOLD_LSB +: HOLD_W];
        out_d  = {seq_entry[STAT_LSB +: STAT_W], seq_entry[CHK_LSB +: CHK_W]};
        oeb_d  = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
    end
  end

`ifdef MPRJ_STIM_ECHO_EN
  logic [15:0] echo_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      echo_q <= '0;
    end else if (start_ok) begin
      echo_q <= '0;
    end else if (expiry && !abort && (io_in != out_q) && (echo_q != 16'hFFFF)) begin
      echo_q <= echo_q + 1'b1;
    end
  end

  assign echo_rd = {16'h0, echo_q};
`else
  logic unused_io_in;
  assign unused_io_in = ^io_in;
  assign echo_rd      = '0;
`endif

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign step_idx = idx_q;
  assign io_out   = out_q;
  assign io_oeb   = oeb_q;

  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr == ADDR_CTRL) begin
      cfg_rdata = {{(31 - IDX_W){1'b0}}, loop_q, last_q};
    end else if (cfg_addr == ADDR_ECHO) begin
      cfg_rdata = echo_rd;
    end else if (cfg_addr == ADDR_STAT) begin
      cfg_rdata = {{(31 - IDX_W){1'b0}}, busy, idx_q};
    end else if (tbl_hit) begin
      cfg_rdata = tbl_rdata;
    end
  end

endmodule

// File: tb/tb_mprj_io_stim_sequencer.sv
// Self-checking bench for mprj_io_stim_sequencer: register-map vectors, directed
// sequences and randomized runs checked against a per-cycle trace built from the table.
module tb_mprj_io_stim_sequencer;

  logic        clock;
  logic        resetb;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [3:0]  step_idx;
  logic [19:0] io_out;
  logic [19:0] io_oeb;
  logic [19:0] io_in;
  logic        echo_flip;

  int n_vec = 0;
  int n_err = 0;

  mprj_io_stim_sequencer dut (
    .clock    (clock),
    .resetb   (resetb),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .io_in    (io_in)
  );

  // Pad loopback, optionally corrupted while entry 1 is driven
  assign io_in = (echo_flip && step_idx == 4'd1) ? (io_out ^ 20'h1) : io_out;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [19:0] out;
    logic [19:0] oeb;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } cyc_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  localparam cyc_t Released = '{out: 20'h0, oeb: 20'hFFFFF, busy: 1'b0, done: 1'b0, idx: 4'd0};

  logic [31:0] tbl [16];
  cyc_t        exp_q [$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ent(int h, logic [3:0] s, logic [15:0] c);
    return {12'(h), s, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_cyc(input string name, input cyc_t e);
    cyc_t a;
    a = '{out: io_out, oeb: io_oeb, busy: busy, done: done, idx: step_idx};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got out=%h oeb=%h busy=%b done=%b idx=%0d, expected out=%h oeb=%h busy=%b done=%b idx=%0d",
               name, a.out, a.oeb, a.busy, a.done, a.idx, e.out, e.oeb, e.busy, e.done, e.idx);
    end
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic cfg_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
    cfg_addr = addr;
    #1;
    chk(name, cfg_rdata, exp);
  endtask

  // Expected per-cycle outputs: each entry i held tbl[i].hold+1 cycles, then one done cycle
  task automatic build_trace(input int last, input bit loop, input int laps);
    exp_q.delete();
    for (int l = 0; l < (loop ? laps : 1); l++) begin
      for (int i = 0; i <= last; i++) begin
        for (int c = 0; c <= int'(tbl[i][31:20]); c++) begin
          exp_q.push_back('{out: tbl[i][19:0], oeb: 20'h0, busy: 1'b1, done: 1'b0, idx: 4'(i)});
        end
      end
    end
    if (!loop) begin
      exp_q.push_back('{out: tbl[last][19:0], oeb: 20'h0, busy: 1'b0, done: 1'b1,
                        idx: 4'(last)});
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_trace(input string name);
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cyc($sformatf("%s[%0d]", name, k), exp_q[k]);
      if (k != exp_q.size() - 1) step();
    end
  endtask

  reg_vec_t regv [9];
  cyc_t     idle_hold;

  initial begin
    resetb    = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    start     = 1'b0;
    abort     = 1'b0;
    echo_flip = 1'b0;

    regv[0] = '{addr: 5'd3,  wdata: 32'h0071_2345, exp: 32'h0071_2345};
    regv[1] = '{addr: 5'd15, wdata: 32'hFFF5_AAAA, exp: 32'hFFF5_AAAA};
    regv[2] = '{addr: 5'd0,  wdata: 32'h0000_0000, exp: 32'h0000_0000};
    regv[3] = '{addr: 5'd31, wdata: 32'h0000_0012, exp: 32'h0000_0012};
    regv[4] = '{addr: 5'd31, wdata: 32'hFFFF_FFE7, exp: 32'h0000_0007};
    regv[5] = '{addr: 5'd20, wdata: 32'h0000_DEAD, exp: 32'h0000_0000};
    regv[6] = '{addr: 5'd16, wdata: 32'h1234_5678, exp: 32'h0000_0000};
    regv[7] = '{addr: 5'd29, wdata: 32'h0000_1234, exp: 32'h0000_0000};
    regv[8] = '{addr: 5'd30, wdata: 32'h0000_5555, exp: 32'h0000_0000};

    // Reset values while resetb is held low
    step();
    step();
    check_cyc("reset", Released);
    cfg_check("reset_ctrl", 5'd31, 32'h0);
    resetb = 1'b1;
    step();
    check_cyc("post_reset", Released);

    for (int i = 0; i < 9; i++) begin
      cfg_write(regv[i].addr, regv[i].wdata);
      cfg_check($sformatf("regmap[%0d]", i), regv[i].addr, regv[i].exp);
    end

    // Basic non-loop run
    tbl[0] = ent(3, 4'h0, 16'hAB40);
    tbl[1] = ent(0, 4'hA, 16'h198F);
    tbl[2] = ent(9, 4'h5, 16'h1DDC);
    for (int i = 0; i < 3; i++) cfg_write(5'(i), tbl[i]);
    cfg_write(5'd31, 32'h0000_0002);
    build_trace(2, 1'b0, 1);
    start_run();
    run_trace("basic");
    idle_hold = '{out: tbl[2][19:0], oeb: 20'h0, busy: 1'b0, done: 1'b0, idx: 4'd2};
    step();
    check_cyc("basic_hold0", idle_hold);
    step();
    check_cyc("basic_hold1", idle_hold);

    // Loop run for three laps, then abort
    cfg_write(5'd31, 32'h0000_0011);
    build_trace(1, 1'b1, 3);
    start_run();
    run_trace("loop");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_cyc("abort", Released);
    step();
    check_cyc("abort_nodone", Released);

    // Start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_cyc("start_abort0", Released);
    step();
    check_cyc("start_abort1", Released);

    // Table writes while entry 1 is driven
    tbl[0] = ent(1, 4'h3, 16'h1111);
    tbl[1] = ent(5, 4'h6, 16'h2222);
    tbl[2] = ent(2, 4'h9, 16'h3333);
    for (int i = 0; i < 3; i++) cfg_write(5'(i), tbl[i]);
    cfg_write(5'd31, 32'h0000_0002);
    tbl[2] = ent(1, 4'hD, 16'hCAFE);
    build_trace(2, 1'b0, 1);
    start_run();
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cyc($sformatf("midwrite[%0d]", k), exp_q[k]);
      cfg_we = 1'b0;
      if (k == 2) begin
        cfg_we    = 1'b1;
        cfg_addr  = 5'd1;
        cfg_wdata = ent(0, 4'hC, 16'hBEEF);
      end else if (k == 3) begin
        cfg_we    = 1'b1;
        cfg_addr  = 5'd2;
        cfg_wdata = tbl[2];
      end
      if (k != exp_q.size() - 1) step();
    end
    cfg_we = 1'b0;
    step();
    tbl[1] = ent(0, 4'hC, 16'hBEEF);
    cfg_check("midwrite_rd1", 5'd1, tbl[1]);

    // Restart after DONE keeps pins enabled; echo counter behaviour
    echo_flip = 1'b1;
    build_trace(2, 1'b0, 1);
    start_run();
    run_trace("echo1");
    step();
`ifdef MPRJ_STIM_ECHO_EN
    cfg_check("echo_count", 5'd30, 32'h1);
`else
    cfg_check("echo_absent", 5'd30, 32'h0);
`endif
    echo_flip = 1'b0;
    start_run();
    cfg_check("echo_clear", 5'd30, 32'h0);
    run_trace("echo2");
    step();

    // Randomized runs against the trace model
    for (int r = 0; r < 8; r++) begin
      int last;
      bit loop;
      int a;
      last = $urandom_range(0, 15);
      loop = 1'($urandom_range(0, 1));
      for (int i = 0; i <= last; i++) begin
        tbl[i] = ent($urandom_range(0, 5), 4'($urandom), 16'($urandom));
        cfg_write(5'(i), tbl[i]);
      end
      cfg_write(5'd31, 32'({loop, 4'(last)}));
      a = $urandom_range(0, last);
      cfg_check($sformatf("rand%0d_rd", r), 5'(a), tbl[a]);
      build_trace(last, loop, 2);
      start_run();
      run_trace($sformatf("rand%0d", r));
      if (loop) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_cyc($sformatf("rand%0d_abort", r), Released);
      end else begin
        step();
        check_cyc($sformatf("rand%0d_idle", r),
                  '{out: tbl[last][19:0], oeb: 20'h0, busy: 1'b0, done: 1'b0, idx: 4'(last)});
      end
    end

    // Asynchronous reset in the middle of a run
    tbl[0] = ent(4, 4'h7, 16'h7777);
    cfg_write(5'd0, tbl[0]);
    cfg_write(5'd31, 32'h0000_0000);
    start_run();
    check_cyc("prereset", '{out: tbl[0][19:0], oeb: 20'h0, busy: 1'b1, done: 1'b0, idx: 4'd0});
    step();
    #2;
    resetb = 1'b0;
    #1;
    check_cyc("async_reset", Released);
    cfg_check("async_reset_ctrl", 5'd31, 32'h0);
    @(negedge clock);
    resetb = 1'b1;
    step();
    check_cyc("after_reset", Released);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
